// File: rtl/sbytes_pkg.sv
// sbytes_pkg: FSM state type, AES forward/inverse S-box tables and beat-count helper
package sbytes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic int nbeats(input int nwords, input int nlanes);
        return (4 * nwords) / nlanes;
    endfunction

endpackage

// File: rtl/sub_bytes_seq_sbox_dual.sv
// sbox_dual: one combinational S-box lane, forward or inverse by inv
module sbox_dual
    import sbytes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = inv ? INV_SBOX[din] : FWD_SBOX[din];

endmodule

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: SubBytes/InvSubBytes over NWords words using NLanes time-multiplexed S-box lanes.
// Define SBYTES_OVERLAP_EN to accept the next block in the same cycle the result is taken.
module sub_bytes_seq
    import sbytes_pkg::*;
#(
    parameter int NWords = 4,
    parameter int NLanes = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                inv,
    input  logic [NWords*32-1:0] bytes_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NWords*32-1:0] bytes_out
);

    localparam int NBytes = 4 * NWords;
    localparam int NBeats = nbeats(NWords, NLanes);
    localparam int BW = (NBeats > 1) ? $clog2(NBeats) : 1;

    if ((NBytes % NLanes) != 0) begin : g_bad_lanes
        $error("sub_bytes_seq: NLanes must divide 4*NWords");
    end

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [NWords*32-1:0] work_q, work_d;
    logic                mode_q, mode_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          lane_in  [NLanes];
    logic [7:0]          lane_out [NLanes];
    logic                last_beat;

    for (genvar g = 0; g < NLanes; g++) begin : g_lane
        assign lane_in[g] = work_q[(int'(beat_q) * NLanes + g) * 8 +: 8];
        sbox_dual u_sbox (
            .inv  (mode_q),
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

`ifdef SBYTES_OVERLAP_EN
    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign last_beat = (beat_q == BW'(NBeats - 1));
    assign out_valid = out_valid_q;
    assign bytes_out = work_q;

    // Next-state: load on input handshake, retire on output handshake, otherwise substitute one beat of lanes
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        work_d      = work_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        if (in_valid && in_ready) begin
            state_d     = RUN;
            beat_d      = '0;
            work_d      = bytes_in;
            mode_d      = inv;
            out_valid_d = 1'b0;
        end else if (state_q == DONE && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < NLanes; k++) begin
                work_d[(int'(beat_q) * NLanes + k) * 8 +: 8] = lane_out[k];
            end
            beat_d      = last_beat ? beat_q : beat_q + 1'b1;
            state_d     = last_beat ? DONE : RUN;
            out_valid_d = last_beat;
        end
    end

    // State registers; reset aborts any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            work_q      <= work_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: scoreboard bench for sub_bytes_seq with directed AES S-box vectors (default NWords/NLanes)
module tb_sub_bytes_seq;

    localparam int W = 128;
    localparam logic [W-1:0] ALL00 = '0;
    localparam logic [W-1:0] ALL63 = {16{8'h63}};
    localparam logic [W-1:0] ALL52 = {16{8'h52}};
    localparam logic [W-1:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [W-1:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         inv;
    logic [W-1:0] bytes_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bytes_out;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic ov_prev = 1'b0;
    logic [W-1:0] sb[$];
    time tq[$];
    time t_last;

    sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inv       (inv),
        .bytes_in  (bytes_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bytes_out (bytes_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one block; the expected result is queued at the handshake edge.
    // inv and bytes_in are scrambled afterwards to show they are ignored outside the handshake.
    task automatic send(input logic [W-1:0] d, input logic m, input logic [W-1:0] e);
        int n = 0;
        bytes_in = d;
        inv = m;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            chk("in_ready_timeout", 1, 0);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        t_last = $time;
        tq.push_back($time);
        #1;
        in_valid = 1'b0;
        inv = ~m;
        bytes_in = ~d;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", W'(sb.size()), 0);
    endtask

    // Monitor: latency on each rising out_valid, data compared on each output handshake
    always @(negedge clk) begin
        if (out_valid && !ov_prev && tq.size() > 0)
            chk("latency", W'(($time - 5 - tq[0]) / 10), 4);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", bytes_out, 'x);
            end else begin
                chk("data", bytes_out, sb.pop_front());
                if (tq.size() > 0) void'(tq.pop_front());
                n_out++;
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        int k;
        int n;
        time t1;
        time t2;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        inv = 1'b0;
        bytes_in = '0;
        #12;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_bytes_out", bytes_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(ALL00, 1'b0, ALL63);
        send({{15{8'h00}}, 8'h53}, 1'b0, {{15{8'h63}}, 8'hed});
        send({{15{8'h00}}, 8'h01}, 1'b0, {{15{8'h63}}, 8'h7c});
        send(ALL63, 1'b1, ALL00);
        send(ALL00, 1'b1, ALL52);
        send({8'hed, {15{8'h00}}}, 1'b1, {8'h53, {15{8'h52}}});
        send(FIPS_IN, 1'b0, FIPS_OUT);
        send(FIPS_OUT, 1'b1, FIPS_IN);
        drain();

        // Back-to-back throughput with out_ready held high
        send(FIPS_IN, 1'b0, FIPS_OUT);
        t1 = t_last;
        send(FIPS_OUT, 1'b1, FIPS_IN);
        t2 = t_last;
`ifdef SBYTES_OVERLAP_EN
        chk("b2b_interval_a", W'((t2 - t1) / 10), 5);
`else
        chk("b2b_interval_a", W'((t2 - t1) / 10), 6);
`endif
        send(ALL00, 1'b0, ALL63);
`ifdef SBYTES_OVERLAP_EN
        chk("b2b_interval_b", W'((t_last - t2) / 10), 5);
`else
        chk("b2b_interval_b", W'((t_last - t2) / 10), 6);
`endif
        drain();

        // Backpressure: result held stable, no new block taken
        out_ready = 1'b0;
        send(ALL00, 1'b0, ALL63);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", W'(out_valid), 1);
        in_valid = 1'b1;
        bytes_in = FIPS_IN;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_stable", bytes_out, ALL63);
            chk("bp_in_ready", W'(in_ready), 0);
            chk("bp_hold_valid", W'(out_valid), 1);
        end
        in_valid = 1'b0;
        k = n_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_one_transfer", W'(n_out - k), 1);
        chk("bp_idle_valid", W'(out_valid), 0);
        chk("bp_idle_ready", W'(in_ready), 1);

        // Reset mid-RUN at beat 2
        send(ALL00, 1'b0, ALL63);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_in_ready", W'(in_ready), 1);
        chk("abort_bytes_out", bytes_out, 0);
        sb.delete();
        tq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(FIPS_IN, 1'b0, FIPS_OUT);
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Mode-selectable AES SubBytes/InvSubBytes unit that processes an `NWords`-word state through `NLanes` time-multiplexed S-box lanes. Blocks enter and leave through valid/ready handshakes. It serves both the encrypt and decrypt datapaths of the AES-128 core. Area and latency are traded through `NLanes`.

## Interface
- `NWords`, default 4: state width in 32-bit words; the block handles 4·`NWords` bytes.
- `NLanes`, default 4: S-box lookups per cycle. Must divide 4·`NWords`; elaboration fails otherwise.
- `clk` in, 1: the only clock. All state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: `bytes_in` and `inv` are presented.
- `in_ready` out, 1: the block can accept a block.
- `inv` in, 1: mode. 0 selects forward S-box; 1 selects inverse S-box. Sampled only at input handshake.
- `bytes_in` in, `NWords`·32: input state. Byte i is `bytes_in[8i+7:8i]`.
- `out_valid` out, 1: `bytes_out` holds a finished result.
- `out_ready` in, 1: the consumer accepts the result.
- `bytes_out` out, `NWords`·32: substituted state, with the same byte ordering as `bytes_in`.

## Operation
- NBeats = 4·`NWords`/`NLanes`.
- FSM states and transitions:
  - IDLE: `in_ready`=1. When `in_valid`·`in_ready`: capture `bytes_in` into the work register and `inv` into the mode register; clear `beat`; go to RUN.
  - RUN: each cycle, replace bytes `beat`·`NLanes` … `beat`·`NLanes`+`NLanes`−1 of the work register with S(x) or InvS(x), chosen by the latched mode. Increment `beat`. After the beat where `beat` = NBeats−1, go to DONE.
  - DONE: `out_valid`=1. When `out_ready`: go to IDLE.
- `in_ready` is a combinational decode of the state, not of `out_ready`. The exception is when `SBYTES_OVERLAP_EN` is defined (see Configuration).
- `beat` counter width is clog2(NBeats), minimum 1 bit. It never wraps: the FSM leaves RUN on the terminal beat.
- The input bus is ignored outside the handshake. `inv` changing during RUN has no effect.
- `bytes_out` is driven directly from the work register. It is stable while `out_valid`·!`out_ready`, and its value is don't-care while `out_valid`=0.
- Reset at any point, including mid-RUN or in DONE, aborts the block with no partial output.
  - After reset: state IDLE, `beat`=0, work register 0, mode 0.
  - Outputs after reset: `out_valid`=0, `in_ready`=1, `bytes_out`=0.

## Timing
- Input handshake at edge E0.
- RUN beats occupy the cycles ending at edges E1…E_NBeats.
- `out_valid` rises after E_NBeats. Latency from handshake to `out_valid` is NBeats cycles.
- With defaults, NBeats=4. With `NLanes`=16, NBeats=1.
- Without overlap, throughput is one block per NBeats+2 cycles when `out_ready` is held at 1.
- S-box lookups are combinational within the cycle. Work register writes are the only pipeline stage.

## Configuration
- `SBYTES_OVERLAP_EN` defined:
  - In DONE, `in_ready` = `out_ready`.
  - A simultaneous output and input handshake loads the new block and goes directly to RUN.
  - Sustained throughput is one block per NBeats+1 cycles.
- `SBYTES_OVERLAP_EN` undefined:
  - `in_ready`=0 in DONE.
  - The block always passes through IDLE between results.

## Structure
- Package `sbytes_pkg` contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - the 256-entry forward and inverse S-box constant tables;
  - a `nbeats(NWords, NLanes)` function.
- Sub-module `sbox_dual`: one combinational lane with ports `inv` and `din[7:0]`, output `dout[7:0]`, indexing the package tables.
  - The top instantiates `NLanes` copies in a generate loop.
  - Each copy is fed by a `beat`-indexed byte select and writes back through an indexed part-select.

## Test plan
- Forward, defaults: `bytes_in` all 0x00, `inv`=0 → after 4 cycles, `out_valid`=1 and `bytes_out` all 0x63. Byte0=0x53 → 0xED; byte0=0x01 → 0x7C.
- Inverse: all 0x63, `inv`=1 → all 0x00. All 0x00 → all 0x52. Byte15=0xED → 0x53.
- Round trip over random 128-bit states, `NLanes` ∈ {1,2,4,8,16}: forward then inverse returns the original. Latency is exactly 16, 8, 4, 2, 1 cycles respectively.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `bytes_out` is stable, `in_ready`=0, and a new `in_valid` is not accepted. Release → one transfer, then IDLE.
- Reset asserted mid-RUN at beat 2 → `out_valid`=0, `in_ready`=1, `bytes_out`=0 immediately. A following block completes with the correct result.
- With `SBYTES_OVERLAP_EN`, back-to-back blocks at `out_ready`=1 → results every 5 cycles (defaults), in order, each with its own `inv` mode.
